// File: rtl/param_accum_cpu_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | param_accum_cpu_if                                                         |
// | Loader / board-I/O bundle of the accumulator CPU.                          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface param_accum_cpu_if #(
  parameter int DW = 8,
  parameter int AW = 5
);
  logic          start;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data;
  logic [DW-1:0] data_in;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] data_out;
  logic          Aeq0;
  logic          Apos;
  logic [2:0]    IR;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;

  // master: program loader and board I/O; slave: the CPU
  modport master (
    output start, prog_we, prog_addr, prog_data, data_in, in_valid,
    input  in_ready, data_out, Aeq0, Apos, IR, pc, busy, halted
  );

  modport slave (
    input  start, prog_we, prog_addr, prog_data, data_in, in_valid,
    output in_ready, data_out, Aeq0, Apos, IR, pc, busy, halted
  );
endinterface
`default_nettype wire

// File: rtl/param_accum_cpu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | param_accum_cpu                                                            |
// | Accumulator machine: 2^AW x DW unified RAM, fetch/execute controller,      |
// | IN handshake and halt/program-load mode.                                   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module param_accum_cpu #(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  param_accum_cpu_if.slave  bus
);

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_STORE = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_IN    = 3'd4;
  localparam logic [2:0] OP_JZ    = 3'd5;
  localparam logic [2:0] OP_JPOS  = 3'd6;
  localparam logic [2:0] OP_HALT  = 3'd7;

  localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t        state;
  logic [DW-1:0] acc;
  logic [2:0]    ir_op;
  logic [AW-1:0] ir_addr;
  logic [AW-1:0] pc_q;
  logic          in_ready_q;
  logic          busy_q;
  logic          halted_q;

  logic [DW-1:0] mem [2**AW];

  logic          parked;
  logic          prog_wr;
  logic          store_wr;
  logic          mem_we;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] operand_word;
  logic [2:0]    fetch_op;
  logic [AW-1:0] fetch_addr;

  assign parked       = (state == IDLE) || (state == HALTED);
  assign prog_wr      = parked && bus.prog_we;
  assign store_wr     = (state == EXEC) && (ir_op == OP_STORE);
  // Reset blocks every write, including a STORE caught mid-EXEC.
  assign mem_we       = !rst && (prog_wr || store_wr);
  assign wr_addr      = prog_wr ? bus.prog_addr : ir_addr;
  assign wr_data      = prog_wr ? bus.prog_data : acc;
  assign operand_word = mem[ir_addr];
  assign fetch_op     = mem[pc_q][DW-1:DW-3];
  assign fetch_addr   = mem[pc_q][AW-1:0];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      ir_op      <= 3'd0;
      ir_addr    <= '0;
      pc_q       <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (bus.start) begin
            state    <= FETCH;
            pc_q     <= '0;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
          end
        end
        FETCH: begin
          ir_op      <= fetch_op;
          ir_addr    <= fetch_addr;
          pc_q       <= pc_q + PC_ONE;
          in_ready_q <= (fetch_op == OP_IN);
          state      <= EXEC;
        end
        EXEC: begin
          state <= FETCH;
          case (ir_op)
            OP_LOAD:  acc <= operand_word;
            OP_STORE: ;
            OP_ADD:   acc <= acc + operand_word;
            OP_SUB:   acc <= acc - operand_word;
            OP_IN: begin
              if (bus.in_valid) begin
                acc        <= bus.data_in;
                in_ready_q <= 1'b0;
              end else begin
                state <= EXEC;
              end
            end
            OP_JZ: begin
              if (acc == '0) pc_q <= ir_addr;
            end
            OP_JPOS: begin
              if (!acc[DW-1]) pc_q <= ir_addr;
            end
            OP_HALT: begin
              state    <= HALTED;
              busy_q   <= 1'b0;
              halted_q <= 1'b1;
            end
          endcase
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.halted   = halted_q;
  assign bus.data_out = acc;
  assign bus.Aeq0     = (acc == '0);
  assign bus.Apos     = ~acc[DW-1];
  assign bus.IR       = ir_op;
  assign bus.pc       = pc_q;

endmodule
`default_nettype wire

// File: doc/param_accum_cpu.md
# param_accum_cpu

Parametrised successor to the general datapath: an accumulator machine with data width DW and 2^AW-word unified RAM. It has an on-chip fetch/execute controller, an input handshake and a halt/program-load mode, so the datapath is no longer driven by external control lines. It sits between the program loader and the board I/O: data_in/data_out plus flags Aeq0/Apos.

## Interface
- DW, 8, data/instruction width; must satisfy DW >= AW+3
- AW, 5, RAM address and PC width; RAM depth 2^AW
- Clock  in  1  single clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high
- start  in  1  leave IDLE/HALTED, PC<=0, begin fetching
- prog_we  in  1  RAM write strobe, honoured only in IDLE/HALTED
- prog_addr  in  AW  RAM write address for prog_we
- prog_data  in  DW  RAM write data for prog_we
- data_in  in  DW  input operand for IN
- in_valid  in  1  data_in valid
- in_ready  out  1  high while executing IN
- data_out  out  DW  accumulator A
- Aeq0  out  1  A == 0
- Apos  out  1  ~A[DW-1] (nonnegative)
- IR  out  3  current opcode, IR[DW-1:DW-3]
- pc  out  AW  program counter
- busy  out  1  state is FETCH or EXEC
- halted  out  1  state is HALTED

## Operation
- Instruction: opcode = IR[DW-1:DW-3], operand address = IR[AW-1:0], middle bits ignored.
- Opcodes:
  - 000 LOAD A<=M[a]
  - 001 STORE M[a]<=A
  - 010 ADD A<=A+M[a]
  - 011 SUB A<=A-M[a]
  - 100 IN A<=data_in after handshake
  - 101 JZ: if Aeq0, PC<=a
  - 110 JPOS: if Apos, PC<=a
  - 111 HALT
- RAM: 2^AW x DW, combinational read, synchronous write, not reset.
- Write port mux: prog_* in IDLE/HALTED, STORE in EXEC.
- Arithmetic is modulo 2^DW; there is no carry/overflow output.
- FSM states: IDLE, FETCH, EXEC, HALTED.
  - IDLE/HALTED: start -> FETCH with PC<=0. A is preserved.
  - FETCH: IR<=M[PC], PC<=PC+1 (wraps 2^AW-1 -> 0) -> EXEC.
  - EXEC, non-IN opcodes: perform op -> FETCH. HALT goes -> HALTED instead.
  - EXEC, IN: in_ready=1. Hold state and PC until in_valid; on the in_valid cycle A<=data_in -> FETCH.
- Jumps not taken leave PC at the already-incremented value.
- Flags are combinational from A and update the cycle after A is written.

## Timing
- Reset values: A=0, data_out=0, Aeq0=1, Apos=1, IR=0, pc=0, in_ready=0, busy=0, halted=0, state IDLE. RAM contents unchanged.
- Reset overrides everything, including mid-instruction and mid-IN-wait. STORE in EXEC on a Reset cycle does not write.
- Non-IN instructions take 2 cycles (FETCH+EXEC). IN takes 2 cycles plus the number of cycles waiting for in_valid.
- After start, the first FETCH is the next cycle and halted drops on that edge. HALT sets halted at the end of its EXEC cycle.
- start and prog_we together in IDLE/HALTED: the write commits and start is taken. The first FETCH sees the new contents.
- start and prog_we while busy: ignored, no RAM write.
- in_valid outside an IN EXEC: ignored, no effect on A.

## Test plan
- Reset: assert Reset 2 cycles with A nonzero -> data_out=0, Aeq0=1, Apos=1, pc=0, busy=0, halted=0, in_ready=0.
- Add/store: load M[0..3]=8'h1E,8'h5F,8'h3D,8'hE0 and M[30]=80, M[31]=75, then start.
  - Required: halted=1 exactly 8 cycles after start; data_out=155 (8'h9B), Apos=0, Aeq0=0.
  - Then load M[0]=8'h1D, M[1]=8'hE0 and start -> data_out=155, proving M[29] was written.
- Sub/branch: program LOAD 31 (75), SUB 30 (80), JPOS 5, HALT at 3, LOAD 30 at 5.
  - Required: data_out=8'hFB (-5), Apos=0, jump not taken, halts with pc=4.
- IN handshake: program IN, JZ 6, HALT at 2, HALT at 6; hold in_valid=0 for 5 cycles.
  - Required: in_ready=1 throughout, pc frozen at 1.
  - Then in_valid=1 with data_in=0 -> A=0, Aeq0=1, JZ taken, halts with pc=7.
- PC wrap: program M[0]=JZ 31, M[31]=8'h1E (LOAD 30), M[30]=7, M[1]=HALT.
  - Required: after the LOAD at 31, pc=0 and then 1; final A=7, pc=2.
- Mid-run disturbance: pulse start and prog_we (address 30, data 8'hAA) during busy -> no effect on M[30] or flow. Assert Reset during an IN wait -> IDLE, in_ready=0, A=0 next cycle.
